// File: rtl/cnt_pkg.sv
// Shared constants and configuration helpers for the modulo-N counter family.
package cnt_pkg;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // Smallest width w with 2^w >= n.
    function automatic int cnt_min_width(input int n);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(n))
            w++;
        return w;
    endfunction

    function automatic bit cnt_cfg_ok(input int width, input int modulus);
        return (modulus >= 2) && (width >= cnt_min_width(modulus));
    endfunction

endpackage

// File: rtl/cnt_modn_next.sv
// Next-state logic for the modulo-N counter: clear, range-checked load, up/down count.
module cnt_modn_next
    import cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 12
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             ud_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             cnt_i,
    output logic [WIDTH-1:0] q_nxt_o,
    output logic             wrap_o,
    output logic             lderr_o
);

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    // One extra bit so N = 2^WIDTH is representable and every D is in range.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

    logic d_ok;
    assign d_ok = ({1'b0, d_i} < MOD_X);

    always_comb begin
        q_nxt_o = q_i;
        wrap_o  = 1'b0;
        lderr_o = 1'b0;
        if (clr_i) begin
            q_nxt_o = '0;
        end else if (load_i) begin
            if (d_ok) begin
                q_nxt_o = d_i;
            end else begin
                q_nxt_o = '0;
                lderr_o = 1'b1;
            end
        end else if (cnt_i) begin
            if (ud_i == UP) begin
                if (q_i == LAST) begin
                    q_nxt_o = '0;
                    wrap_o  = 1'b1;
                end else begin
                    q_nxt_o = q_i + 1'b1;
                end
            end else begin
                if (q_i == '0) begin
                    q_nxt_o = LAST;
                    wrap_o  = 1'b1;
                end else begin
                    q_nxt_o = q_i - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cnt_modn.sv
// Synchronous modulo-N up/down counter with HC161-style CEP/CET/TC cascading.
module cnt_modn
    import cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 12
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic             SR,
    input  logic             PE,
    input  logic [WIDTH-1:0] D,
    input  logic             CEP,
    input  logic             CET,
    input  logic             UD,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP,
    output logic             LDERR
);

    if (!cnt_cfg_ok(WIDTH, MODULUS)) begin : g_bad_cfg
        $error("cnt_modn: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
    end

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             lderr_q, lderr_d;

    cnt_modn_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q_i     (q_q),
        .ud_i    (UD),
        .d_i     (D),
        .clr_i   (~SR),
        .load_i  (~PE),
        .cnt_i   (CEP & CET),
        .q_nxt_o (q_d),
        .wrap_o  (wrap_d),
        .lderr_o (lderr_d)
    );

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            q_q     <= '0;
            wrap_q  <= 1'b0;
            lderr_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            wrap_q  <= wrap_d;
            lderr_q <= lderr_d;
        end
    end

    // TC is gated by CET only, so a stalled lower stage cannot ripple a carry.
    assign TC    = CET & ((UD == UP) ? (q_q == LAST) : (q_q == '0));
    assign Q     = q_q;
    assign WRAP  = wrap_q;
    assign LDERR = lderr_q;

endmodule

// File: tb/tb_cnt_modn.sv
// Directed bench for cnt_modn: vector table plus reset, long-count and cascade sequences.
module tb_cnt_modn;

    logic       clk;
    logic       mr, sr, pe, cep, cet, ud;
    logic [3:0] d;
    logic [3:0] q0;
    logic       tc0, wrap0, lderr0;
    logic [2:0] q1;
    logic       tc1, wrap1, lderr1;

    int total = 0;
    int bad   = 0;

    cnt_modn #(.WIDTH(4), .MODULUS(12)) dut (
        .Clk(clk), .MR(mr), .SR(sr), .PE(pe), .D(d), .CEP(cep), .CET(cet), .UD(ud),
        .Q(q0), .TC(tc0), .WRAP(wrap0), .LDERR(lderr0)
    );

    cnt_modn #(.WIDTH(3), .MODULUS(5)) dut_hi (
        .Clk(clk), .MR(mr), .SR(sr), .PE(pe), .D(d[2:0]), .CEP(cep), .CET(tc0), .UD(ud),
        .Q(q1), .TC(tc1), .WRAP(wrap1), .LDERR(lderr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sr, pe;
        logic [3:0] d;
        logic       cep, cet, ud;
        logic [3:0] q;
        logic       tc, wrap, lderr;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic s, logic p, logic [3:0] dd, logic ep, logic et, logic u,
                                logic [3:0] eq, logic etc, logic ew, logic el);
        vec_t v;
        v.sr = s; v.pe = p; v.d = dd; v.cep = ep; v.cet = et; v.ud = u;
        v.q = eq; v.tc = etc; v.wrap = ew; v.lderr = el;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic s, logic p, logic [3:0] dd, logic ep, logic et, logic u);
        sr = s; pe = p; d = dd; cep = ep; cet = et; ud = u;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        mr = 1'b0;
        drive(1, 1, 0, 1, 1, 1);

        // reset state
        #3;
        check("rst_q", q0, 0);
        check("rst_wrap", wrap0, 0);
        check("rst_lderr", lderr0, 0);
        check("rst_tc", tc0, 0);
        step();
        check("rst_hold_q", q0, 0);

        // 24 up-count edges: 0..11 twice, wrap on edges 12 and 24
        @(negedge clk);
        mr = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            check($sformatf("up%0d_q", k), q0, k % 12);
            check($sformatf("up%0d_wrap", k), wrap0, (k % 12 == 0) ? 1 : 0);
            check($sformatf("up%0d_tc", k), tc0, (k % 12 == 11) ? 1 : 0);
            @(negedge clk);
        end

        //           sr pe d   cep cet ud   q   tc wr le
        tv.push_back(mk(1, 1, 0,  1, 1, 0,  11, 0, 1, 0));
        tv.push_back(mk(1, 1, 0,  1, 1, 0,  10, 0, 0, 0));
        tv.push_back(mk(1, 1, 0,  1, 1, 0,   9, 0, 0, 0));
        tv.push_back(mk(1, 0, 5,  1, 1, 0,   5, 0, 0, 0));
        tv.push_back(mk(1, 1, 0,  1, 1, 1,   6, 0, 0, 0));
        tv.push_back(mk(1, 1, 0,  1, 1, 0,   5, 0, 0, 0));
        tv.push_back(mk(1, 1, 0,  1, 1, 0,   4, 0, 0, 0));
        tv.push_back(mk(1, 0, 9,  1, 1, 0,   9, 0, 0, 0));
        tv.push_back(mk(1, 0, 13, 1, 1, 1,   0, 0, 0, 1));
        tv.push_back(mk(1, 1, 0,  0, 1, 1,   0, 0, 0, 0));
        tv.push_back(mk(1, 0, 11, 1, 1, 1,  11, 1, 0, 0));
        tv.push_back(mk(1, 1, 0,  1, 1, 1,   0, 0, 1, 0));
        tv.push_back(mk(1, 0, 11, 1, 1, 1,  11, 1, 0, 0));
        for (int i = 0; i < 5; i++) tv.push_back(mk(1, 1, 0, 1, 0, 1, 11, 0, 0, 0));
        for (int i = 0; i < 5; i++) tv.push_back(mk(1, 1, 0, 0, 1, 1, 11, 1, 0, 0));
        tv.push_back(mk(0, 0, 13, 1, 1, 1,   0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0,  1, 1, 0,   0, 1, 0, 0));
        tv.push_back(mk(1, 1, 0,  1, 1, 0,  11, 0, 1, 0));
        tv.push_back(mk(1, 0, 11, 1, 1, 1,  11, 1, 0, 0));
        tv.push_back(mk(0, 1, 0,  1, 1, 1,   0, 0, 0, 0));

        foreach (tv[i]) begin
            drive(tv[i].sr, tv[i].pe, tv[i].d, tv[i].cep, tv[i].cet, tv[i].ud);
            step();
            check($sformatf("v%0d_q", i), q0, tv[i].q);
            check($sformatf("v%0d_tc", i), tc0, tv[i].tc);
            check($sformatf("v%0d_wrap", i), wrap0, tv[i].wrap);
            check($sformatf("v%0d_lderr", i), lderr0, tv[i].lderr);
            @(negedge clk);
        end

        // asynchronous MR mid-count at Q=7
        drive(1, 0, 7, 1, 1, 1);
        step();
        check("mr_pre_q", q0, 7);
        @(negedge clk);
        drive(1, 1, 0, 1, 1, 1);
        #1 mr = 1'b0;
        #1;
        check("mr_async_q", q0, 0);
        check("mr_async_wrap", wrap0, 0);
        check("mr_async_lderr", lderr0, 0);
        step();
        check("mr_held_q", q0, 0);
        @(negedge clk);
        mr = 1'b1;
        step();
        check("mr_resume_q", q0, 1);

        // two-stage cascade 12 x 5 wraps at edge 60
        @(negedge clk);
        mr = 1'b0;
        #1 mr = 1'b1;
        #1;
        check("cas_rst_lo", q0, 0);
        check("cas_rst_hi", q1, 0);
        for (int k = 1; k <= 60; k++) begin
            step();
            check($sformatf("cas%0d_lo", k), q0, k % 12);
            check($sformatf("cas%0d_hi", k), q1, (k / 12) % 5);
            if (k == 59) check("cas59_tc_hi", tc1, 1);
            if (k == 60) check("cas60_wrap_hi", wrap1, 1);
            if (k == 12) check("cas12_wrap_hi", wrap1, 0);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
